fft_bfp_scale_ctrl: RTL and testbench

Block-floating-point stage scheduler for the FFT datapath. It sequences the per-stage rescale enable of the rescale unit across all butterfly stages. It monitors each stage's output samples for guard-bit hits and decides whether the next stage is scaled by 2. It accumulates the block exponent and a per-stage shift mask, and reports completion to the top-level FFT controller.

---
 rtl/fft_bfp_pkg.sv | 35 +++
 rtl/fft_bfp_scale_ctrl_guard_monitor.sv | 32 +++
 rtl/fft_bfp_scale_ctrl.sv | 155 +++++++++++++++
 tb/tb_fft_bfp_scale_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_bfp_pkg.sv
// Shared types and helpers for the block-floating-point FFT stage scheduler.
package fft_bfp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_RUN,
      ST_EVAL,
      ST_DONE
   } state_t;

   localparam int          MIN_LOG2_N = 3;
   localparam int          HIT_CNT_W  = 8;
   localparam int unsigned MAX_DW     = 64;

   // Guard-bit hit: the two MSBs of either component disagree at width dw.
   function automatic logic guard_hit(input logic [MAX_DW-1:0] re,
                                      input logic [MAX_DW-1:0] im,
                                      input int unsigned       dw);
      logic [MAX_DW-1:0] w_re_al;
      logic [MAX_DW-1:0] w_im_al;
      w_re_al = re << (MAX_DW - dw);
      w_im_al = im << (MAX_DW - dw);
      return (w_re_al[MAX_DW-1] ^ w_re_al[MAX_DW-2]) |
             (w_im_al[MAX_DW-1] ^ w_im_al[MAX_DW-2]);
   endfunction

   function automatic logic [3:0] clamp_log2(input logic [3:0] v,
                                             input logic [3:0] max_l);
      if (v < 4'(MIN_LOG2_N)) return 4'(MIN_LOG2_N);
      if (v > max_l)          return max_l;
      return v;
   endfunction

endpackage

// File: rtl/fft_bfp_scale_ctrl_guard_monitor.sv
// Per-sample guard-bit hit detection with a saturating hit counter.
module fft_guard_monitor
   import fft_bfp_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  clear_i,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] real_i,
   input  logic [DATA_WIDTH-1:0] imag_i,
   output logic [HIT_CNT_W-1:0]  hit_count_o
);

   logic                 w_hit;
   logic [HIT_CNT_W-1:0] r_hit_count;

   assign w_hit       = guard_hit(MAX_DW'(real_i), MAX_DW'(imag_i), DATA_WIDTH);
   assign hit_count_o = r_hit_count;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_hit_count <= '0;
      end else if (clear_i) begin
         r_hit_count <= '0;
      end else if (valid_i && w_hit && (r_hit_count != '1)) begin
         r_hit_count <= r_hit_count + HIT_CNT_W'(1);
      end
   end

endmodule

// File: rtl/fft_bfp_scale_ctrl.sv
// Sequences per-stage rescale enables for a block-floating-point FFT and
// accumulates the block exponent and per-stage shift mask.
module fft_bfp_scale_ctrl
   import fft_bfp_pkg::*;
#(
   parameter int DATA_WIDTH         = 16,
   parameter int LOG2_N_MAX         = 10,
   parameter int SCALE_FACTOR_WIDTH = 8
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          start_i,
   input  logic                          abort_i,
   input  logic [3:0]                    log2_size_i,
   input  logic                          auto_scale_en_i,
   input  logic                          scale_mode_i,
   input  logic [7:0]                    threshold_i,
   input  logic                          sample_valid_i,
   input  logic [DATA_WIDTH-1:0]         sample_real_i,
   input  logic [DATA_WIDTH-1:0]         sample_imag_i,
   output logic                          stage_start_o,
   output logic [3:0]                    stage_idx_o,
   output logic                          rescale_en_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [SCALE_FACTOR_WIDTH-1:0] block_exp_o,
   output logic [LOG2_N_MAX-1:0]         shift_mask_o,
   output logic [7:0]                    hit_count_o,
   output logic                          final_ovf_o
);

   localparam logic [3:0] L_MAX = 4'(LOG2_N_MAX);

   state_t                          r_state;
   state_t                          w_next;
   logic [3:0]                      r_log2;
   logic [3:0]                      r_stage;
   logic                            r_pending;
   logic                            r_rescale;
   logic                            r_final_ovf;
   logic [SCALE_FACTOR_WIDTH-1:0]   r_block_exp;
   logic [LOG2_N_MAX-1:0]           r_mask;
   logic [LOG2_N_MAX:0]             r_sample_cnt;
   logic [LOG2_N_MAX:0]             w_last_idx;
   logic                            w_start_ok;
   logic                            w_last_sample;
   logic                            w_last_stage;
   logic                            w_decide;
   logic                            w_mon_clear;
   logic                            w_mon_valid;
   logic [HIT_CNT_W-1:0]            w_hit_count;

   assign w_start_ok    = (r_state == ST_IDLE) && start_i && !abort_i;
   assign w_last_idx    = ((LOG2_N_MAX+1)'(1) << r_log2) - (LOG2_N_MAX+1)'(1);
   assign w_last_sample = sample_valid_i && (r_sample_cnt == w_last_idx);
   assign w_last_stage  = (r_stage == (r_log2 - 4'd1));
   assign w_decide      = scale_mode_i | (auto_scale_en_i & (w_hit_count > threshold_i));
   assign w_mon_clear   = w_start_ok || (r_state == ST_ARM);
   assign w_mon_valid   = (r_state == ST_RUN) && sample_valid_i && !abort_i;

   fft_guard_monitor #(.DATA_WIDTH(DATA_WIDTH)) u_guard_monitor (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .clear_i     (w_mon_clear),
      .valid_i     (w_mon_valid),
      .real_i      (sample_real_i),
      .imag_i      (sample_imag_i),
      .hit_count_o (w_hit_count)
   );

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) r_state <= ST_IDLE;
      else            r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (abort_i) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (start_i) w_next = ST_ARM;
            ST_ARM:  w_next = ST_RUN;
            ST_RUN:  if (w_last_sample) w_next = ST_EVAL;
            ST_EVAL: w_next = w_last_stage ? ST_DONE : ST_ARM;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_o        = (r_state != ST_IDLE);
      stage_start_o = (r_state == ST_ARM)  && !abort_i;
      done_o        = (r_state == ST_DONE) && !abort_i;
   end

   // Status registers hold their partial values across an abort.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_log2       <= '0;
         r_stage      <= '0;
         r_pending    <= 1'b0;
         r_rescale    <= 1'b0;
         r_final_ovf  <= 1'b0;
         r_block_exp  <= '0;
         r_mask       <= '0;
         r_sample_cnt <= '0;
      end else if (abort_i) begin
         r_rescale <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_log2      <= clamp_log2(log2_size_i, L_MAX);
                  r_stage     <= '0;
                  r_pending   <= scale_mode_i;
                  r_final_ovf <= 1'b0;
                  r_block_exp <= '0;
                  r_mask      <= '0;
               end
            end
            ST_ARM: begin
               r_rescale    <= r_pending;
               r_sample_cnt <= '0;
               if (r_pending) begin
                  if (r_block_exp != '1) r_block_exp <= r_block_exp + SCALE_FACTOR_WIDTH'(1);
                  r_mask[r_stage] <= 1'b1;
               end
            end
            ST_RUN: begin
               if (sample_valid_i) r_sample_cnt <= r_sample_cnt + (LOG2_N_MAX+1)'(1);
            end
            ST_EVAL: begin
               if (w_last_stage) begin
                  r_final_ovf <= w_decide;
               end else begin
                  r_pending <= w_decide;
                  r_stage   <= r_stage + 4'd1;
               end
            end
            ST_DONE: r_rescale <= 1'b0;
            default: r_rescale <= 1'b0;
         endcase
      end
   end

   assign stage_idx_o  = r_stage;
   assign rescale_en_o = r_rescale;
   assign block_exp_o  = r_block_exp;
   assign shift_mask_o = r_mask;
   assign hit_count_o  = w_hit_count;
   assign final_ovf_o  = r_final_ovf;

endmodule

// File: tb/tb_fft_bfp_scale_ctrl.sv
// Self-checking bench for the block-floating-point stage scheduler.
module tb_fft_bfp_scale_ctrl;

  localparam int DW   = 16;
  localparam int LMAX = 10;
  localparam int SFW  = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start_i = 1'b0;
  logic            abort_i = 1'b0;
  logic [3:0]      log2_size_i = '0;
  logic            auto_scale_en_i = 1'b0;
  logic            scale_mode_i = 1'b0;
  logic [7:0]      threshold_i = '0;
  logic            sample_valid_i = 1'b0;
  logic [DW-1:0]   sample_real_i = '0;
  logic [DW-1:0]   sample_imag_i = '0;
  logic            stage_start_o;
  logic [3:0]      stage_idx_o;
  logic            rescale_en_o;
  logic            busy_o;
  logic            done_o;
  logic [SFW-1:0]  block_exp_o;
  logic [LMAX-1:0] shift_mask_o;
  logic [7:0]      hit_count_o;
  logic            final_ovf_o;

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  fft_bfp_scale_ctrl #(.DATA_WIDTH(DW), .LOG2_N_MAX(LMAX), .SCALE_FACTOR_WIDTH(SFW)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start_i), .abort_i(abort_i),
    .log2_size_i(log2_size_i), .auto_scale_en_i(auto_scale_en_i),
    .scale_mode_i(scale_mode_i), .threshold_i(threshold_i),
    .sample_valid_i(sample_valid_i), .sample_real_i(sample_real_i),
    .sample_imag_i(sample_imag_i), .stage_start_o(stage_start_o),
    .stage_idx_o(stage_idx_o), .rescale_en_o(rescale_en_o), .busy_o(busy_o),
    .done_o(done_o), .block_exp_o(block_exp_o), .shift_mask_o(shift_mask_o),
    .hit_count_o(hit_count_o), .final_ovf_o(final_ovf_o)
  );

  always @(negedge clk) if (done_o === 1'b1) done_seen++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] quiet_val();
    logic [DW-1:0] v;
    v = DW'($urandom_range(0, 16'h3FFF));
    return ($urandom_range(0, 1) == 1) ? -v : v;
  endfunction

  // Feeds n valid samples with random idle gaps; nhit of them carry a guard hit.
  task automatic feed_stage(input int n, input int nhit, input bit poke_start);
    int k;
    k = 0;
    while (k < n) begin
      if ($urandom_range(0, 3) == 0) begin
        sample_valid_i = 1'b0;
        sample_real_i  = 16'h4000;
        sample_imag_i  = 16'h8000;
      end else begin
        sample_valid_i = 1'b1;
        sample_real_i  = quiet_val();
        sample_imag_i  = quiet_val();
        if (((k + n - 5) % n) < nhit) begin
          if (k % 2 == 1) sample_real_i = 16'h4000;
          else            sample_imag_i = 16'hBFFF;
        end
        k++;
      end
      start_i = poke_start && (k == 7);
      step();
    end
    sample_valid_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic run_transform(input logic [3:0] log2, input bit mode, input bit auto_en,
                               input logic [7:0] thr, input int hits[LMAX],
                               input bit poke_start, input string name);
    int L, n, h, bexp;
    logic [LMAX-1:0] mask;
    logic pending, d, fovf, e;
    logic [7:0] hexp[LMAX];
    L = (log2 < 3) ? 3 : ((log2 > LMAX) ? LMAX : int'(log2));
    n = 1 << L;
    pending = mode; bexp = 0; mask = '0; fovf = 1'b0;
    for (int s = 0; s < L; s++) begin
      exp_q.push_back(pending);
      if (pending) begin bexp++; mask[s] = 1'b1; end
      h = (hits[s] > 255) ? 255 : hits[s];
      hexp[s] = 8'(h);
      d = mode | (auto_en && (h > int'(thr)));
      pending = d; fovf = d;
    end
    log2_size_i = log2; scale_mode_i = mode; auto_scale_en_i = auto_en; threshold_i = thr;
    done_seen = 0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    n_vec++; if (stage_start_o !== 1'b1) begin n_err++; $display("FAIL %s start latency: stage_start_o=%0b want 1", name, stage_start_o); end
    n_vec++; if ({busy_o, block_exp_o, shift_mask_o, hit_count_o, final_ovf_o, stage_idx_o} !== {1'b1, 8'd0, 10'd0, 8'd0, 1'b0, 4'd0}) begin
      n_err++; $display("FAIL %s cleared status: busy=%0b exp=%0d mask=%h hits=%0d ovf=%0b idx=%0d", name, busy_o, block_exp_o, shift_mask_o, hit_count_o, final_ovf_o, stage_idx_o); end
    for (int s = 0; s < L; s++) begin
      if (s > 0) begin
        n_vec++; if (stage_start_o !== 1'b1 || stage_idx_o !== 4'(s)) begin
          n_err++; $display("FAIL %s stage %0d start: stage_start_o=%0b idx=%0d want 1/%0d", name, s, stage_start_o, stage_idx_o, s); end
      end
      step();
      e = exp_q.pop_front();
      n_vec++; if (rescale_en_o !== e) begin n_err++; $display("FAIL %s rescale stage %0d: got %0b want %0b", name, s, rescale_en_o, e); end
      feed_stage(n, hits[s], poke_start && (s == 1));
      n_vec++; if (hit_count_o !== hexp[s] || done_o !== 1'b0) begin
        n_err++; $display("FAIL %s hit_count stage %0d: got %0d want %0d (done=%0b)", name, s, hit_count_o, hexp[s], done_o); end
      step();
    end
    n_vec++; if (done_o !== 1'b1 || busy_o !== 1'b1) begin n_err++; $display("FAIL %s done latency: done=%0b busy=%0b want 1/1", name, done_o, busy_o); end
    n_vec++; if (block_exp_o !== SFW'(bexp) || shift_mask_o !== mask || final_ovf_o !== fovf) begin
      n_err++; $display("FAIL %s result: exp=%0d mask=%h ovf=%0b want %0d/%h/%0b", name, block_exp_o, shift_mask_o, final_ovf_o, bexp, mask, fovf); end
    step();
    n_vec++; if (busy_o !== 1'b0 || done_o !== 1'b0 || rescale_en_o !== 1'b0 || done_seen != 1 || block_exp_o !== SFW'(bexp) || shift_mask_o !== mask) begin
      n_err++; $display("FAIL %s idle after done: busy=%0b done=%0b rescale=%0b pulses=%0d exp=%0d mask=%h", name, busy_o, done_o, rescale_en_o, done_seen, block_exp_o, shift_mask_o); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    n_vec++; if ({stage_start_o, stage_idx_o, rescale_en_o, busy_o, done_o, block_exp_o, shift_mask_o, hit_count_o, final_ovf_o} !== '0) begin
      n_err++; $display("FAIL reset outputs: busy=%0b idx=%0d exp=%0d mask=%h hits=%0d", busy_o, stage_idx_o, block_exp_o, shift_mask_o, hit_count_o); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_conditional();
    int hits[LMAX];
    hits = '{default: 0};
    run_transform(4'd3, 1'b0, 1'b1, 8'd0, hits, 1'b0, "no_hits");
    hits[0] = 1;
    run_transform(4'd3, 1'b0, 1'b1, 8'd0, hits, 1'b0, "single_hit");
    hits = '{default: 0};
    run_transform(4'd4, 1'b1, 1'b1, 8'd0, hits, 1'b0, "scale_all");
  endtask

  task automatic test_threshold();
    int hits[LMAX];
    hits = '{default: 0};
    hits[0] = 2;
    run_transform(4'd3, 1'b0, 1'b1, 8'd2, hits, 1'b0, "thr2_2hits");
    hits[0] = 3;
    run_transform(4'd3, 1'b0, 1'b1, 8'd2, hits, 1'b0, "thr2_3hits");
    hits[0] = 8; hits[1] = 8;
    run_transform(4'd3, 1'b0, 1'b1, 8'd255, hits, 1'b0, "thr255");
    run_transform(4'd3, 1'b0, 1'b0, 8'd0, hits, 1'b0, "auto_off");
    hits = '{default: 0}; hits[2] = 4;
    run_transform(4'd3, 1'b0, 1'b1, 8'd3, hits, 1'b0, "last_stage_ovf");
  endtask

  task automatic test_abort();
    log2_size_i = 4'd9; scale_mode_i = 1'b0; auto_scale_en_i = 1'b1; threshold_i = 8'd0;
    done_seen = 0;
    start_i = 1'b1; step(); start_i = 1'b0;
    step();
    feed_stage(512, 1, 1'b0);
    step();
    n_vec++; if (stage_idx_o !== 4'd1 || stage_start_o !== 1'b1) begin n_err++; $display("FAIL abort stage1 arm: idx=%0d start=%0b want 1/1", stage_idx_o, stage_start_o); end
    step();
    n_vec++; if (rescale_en_o !== 1'b1) begin n_err++; $display("FAIL abort stage1 rescale: got %0b want 1", rescale_en_o); end
    for (int k = 0; k < 300; k++) begin
      sample_valid_i = 1'b1; sample_real_i = 16'h4000; sample_imag_i = quiet_val();
      step();
    end
    sample_valid_i = 1'b0;
    n_vec++; if (hit_count_o !== 8'd255 || busy_o !== 1'b1) begin n_err++; $display("FAIL hit saturation: got %0d busy=%0b want 255/1", hit_count_o, busy_o); end
    abort_i = 1'b1; sample_valid_i = 1'b1;
    step();
    abort_i = 1'b0; sample_valid_i = 1'b0;
    n_vec++; if (busy_o !== 1'b0 || rescale_en_o !== 1'b0 || block_exp_o !== 8'd1 || shift_mask_o !== 10'h002) begin
      n_err++; $display("FAIL abort: busy=%0b rescale=%0b exp=%0d mask=%h want 0/0/1/002", busy_o, rescale_en_o, block_exp_o, shift_mask_o); end
    repeat (3) step();
    n_vec++; if (done_seen != 0 || busy_o !== 1'b0) begin n_err++; $display("FAIL abort no done: pulses=%0d busy=%0b want 0/0", done_seen, busy_o); end
    start_i = 1'b1; abort_i = 1'b1;
    step();
    start_i = 1'b0; abort_i = 1'b0;
    n_vec++; if (busy_o !== 1'b0 || stage_start_o !== 1'b0) begin n_err++; $display("FAIL abort+start idle: busy=%0b start=%0b want 0/0", busy_o, stage_start_o); end
    step();
  endtask

  task automatic test_clamp();
    int hits[LMAX];
    for (int s = 0; s < LMAX; s++) hits[s] = $urandom_range(0, 20);
    run_transform(4'd15, 1'b0, 1'b1, 8'd10, hits, 1'b1, "clamp15");
    hits = '{default: 0}; hits[1] = 5;
    run_transform(4'd1, 1'b0, 1'b1, 8'd0, hits, 1'b0, "clamp1");
  endtask

  task automatic test_reset_mid_arm();
    log2_size_i = 4'd3; scale_mode_i = 1'b1; auto_scale_en_i = 1'b0; threshold_i = 8'd0;
    start_i = 1'b1; step(); start_i = 1'b0;
    step();
    feed_stage(8, 2, 1'b0);
    step();
    n_vec++; if (stage_start_o !== 1'b1 || block_exp_o !== 8'd1 || rescale_en_o !== 1'b1) begin
      n_err++; $display("FAIL pre-reset arm: start=%0b exp=%0d rescale=%0b want 1/1/1", stage_start_o, block_exp_o, rescale_en_o); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if ({stage_start_o, stage_idx_o, rescale_en_o, busy_o, done_o, block_exp_o, shift_mask_o, hit_count_o, final_ovf_o} !== '0) begin
      n_err++; $display("FAIL async reset: start=%0b idx=%0d rescale=%0b busy=%0b exp=%0d mask=%h hits=%0d", stage_start_o, stage_idx_o, rescale_en_o, busy_o, block_exp_o, shift_mask_o, hit_count_o); end
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_conditional();
    test_threshold();
    test_abort();
    begin
      int hits[LMAX];
      hits = '{default: 0};
      run_transform(4'd3, 1'b0, 1'b1, 8'd0, hits, 1'b0, "after_abort");
    end
    test_clamp();
    test_reset_mid_arm();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
